as2650_bus_responder: RTL

- Target-side responder for the AS2650 core's multiplexed external bus. It sits in the user project between the core's pin-level bus signals and a backing byte memory port, plus a small I/O port block.
- Reconstructs the 16-bit address from the le_lo/le_hi latch strobes.
- Serves memory reads and writes, and decodes IOC/IOD cycles into port registers.
- Flags bus protocol violations.

---
 rtl/as2650_bus_responder_if.sv | 35 +++
 rtl/as2650_bus_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/as2650_bus_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | as2650_bus_responder_if: AS2650 pin bus plus backing memory port     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface as2650_bus_responder_if;
  logic [7:0]  bus_out;
  logic        le_lo;
  logic        le_hi;
  logic        oeb;
  logic        web;
  logic        ioc;
  logic        iod;
  logic [7:0]  bus_in;
  logic        bus_in_oe;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  // Responder side
  modport slave (
    input  bus_out, le_lo, le_hi, oeb, web, ioc, iod, mem_rdata, mem_ack,
    output bus_in, bus_in_oe, mem_addr, mem_req, mem_we, mem_wdata
  );

  // Core / memory model side
  modport master (
    output bus_out, le_lo, le_hi, oeb, web, ioc, iod, mem_rdata, mem_ack,
    input  bus_in, bus_in_oe, mem_addr, mem_req, mem_we, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/as2650_bus_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | as2650_bus_responder: address latch, memory/IO cycle FSM, error flag |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module as2650_bus_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RST_PORT_A  = 8'h00
) (
  input  wire logic              wb_clk_i,
  input  wire logic              wb_rst_i,
  as2650_bus_responder_if.slave  bus,
  output logic [7:0]             port_a_out,
  input  wire logic [7:0]        port_b_in,
  output logic                   bus_err
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_HOLD = 3'd2;
  localparam logic [2:0] ST_WR_WAIT = 3'd3;
  localparam logic [2:0] ST_WR_REQ  = 3'd4;

  logic [2:0]  state_q,    state_d;
  logic [15:0] addr_q,     addr_d;
  logic [7:0]  bus_in_q,   bus_in_d;
  logic        oe_q,       oe_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        req_q,      req_d;
  logic        we_q,       we_d;
  logic [7:0]  wdata_q,    wdata_d;
  logic [7:0]  port_a_q,   port_a_d;
  logic        err_q,      err_d;
  logic        abort_q,    abort_d;
  logic        oeb_q;
  logic        web_q;
  logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;

  logic       oeb_fall, oeb_rise, web_fall, web_rise;
  logic       io_cycle, err_level;
  logic [7:0] port_b_sync;

  assign oeb_fall    = oeb_q & ~bus.oeb;
  assign oeb_rise    = ~oeb_q & bus.oeb;
  assign web_fall    = web_q & ~bus.web;
  assign web_rise    = ~web_q & bus.web;
  assign io_cycle    = bus.ioc | bus.iod;
  assign port_b_sync = sync_q[SYNC_STAGES-1];

  // Protocol violations that are visible from pin levels alone
  assign err_level = (~bus.oeb & ~bus.web) |
                     ((bus.le_lo | bus.le_hi) & (~bus.oeb | ~bus.web));

  always_comb begin
    sync_d[0] = port_b_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    addr_d = addr_q;
    if (bus.le_lo) addr_d[7:0]  = bus.bus_out;
    if (bus.le_hi) addr_d[15:8] = bus.bus_out;

    state_d    = state_q;
    bus_in_d   = bus_in_q;
    oe_d       = oe_q;
    mem_addr_d = mem_addr_q;
    req_d      = req_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    port_a_d   = port_a_q;
    abort_d    = abort_q;
    err_d      = err_q | err_level;

    // Decisions use addr_d so a strobe that coincides with a latch sees the new address
    case (state_q)
      ST_IDLE: begin
        if (oeb_fall) begin
          if (io_cycle) begin
            bus_in_d = addr_d[0] ? port_b_sync : port_a_q;
            oe_d     = 1'b1;
            state_d  = ST_RD_HOLD;
          end else begin
            mem_addr_d = addr_d;
            req_d      = 1'b1;
            we_d       = 1'b0;
            abort_d    = 1'b0;
            state_d    = ST_RD_REQ;
          end
        end else if (web_fall) begin
          state_d = ST_WR_WAIT;
        end
      end
      ST_RD_REQ: begin
        if (oeb_fall | web_fall) err_d = 1'b1;
        if (oeb_rise) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
        end
        if (bus.mem_ack) begin
          req_d = 1'b0;
          if (abort_q | oeb_rise) begin
            state_d = ST_IDLE;
          end else begin
            bus_in_d = bus.mem_rdata;
            oe_d     = 1'b1;
            state_d  = ST_RD_HOLD;
          end
        end
      end
      ST_RD_HOLD: begin
        if (bus.oeb) begin
          oe_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_WR_WAIT: begin
        if (web_rise) begin
          if (io_cycle) begin
            if (!addr_d[0]) port_a_d = wdata_q;
            state_d = ST_IDLE;
          end else begin
            mem_addr_d = addr_d;
            req_d      = 1'b1;
            we_d       = 1'b1;
            state_d    = ST_WR_REQ;
          end
        end else if (!bus.web) begin
          wdata_d = bus.bus_out;
        end
      end
      ST_WR_REQ: begin
        if (oeb_fall | web_fall) err_d = 1'b1;
        if (bus.mem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= 16'h0000;
      bus_in_q   <= 8'h00;
      oe_q       <= 1'b0;
      mem_addr_q <= 16'h0000;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= 8'h00;
      port_a_q   <= RST_PORT_A;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
      oeb_q      <= 1'b1;
      web_q      <= 1'b1;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      bus_in_q   <= bus_in_d;
      oe_q       <= oe_d;
      mem_addr_q <= mem_addr_d;
      req_q      <= req_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      port_a_q   <= port_a_d;
      err_q      <= err_d;
      abort_q    <= abort_d;
      oeb_q      <= bus.oeb;
      web_q      <= bus.web;
      sync_q     <= sync_d;
    end
  end

  assign bus.bus_in    = bus_in_q;
  assign bus.bus_in_oe = oe_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_wdata = wdata_q;
  assign port_a_out    = port_a_q;
  assign bus_err       = err_q;

endmodule
`default_nettype wire
